// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit:
// condition codes, BHT counter encodings and the counter update rule.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  function automatic logic [1:0] bht_next(
    input logic [1:0] state,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != ST) nxt = state + 2'd1;
    end else begin
      if (state != SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters.
// Async lookup for fetch, sync training from execute; no bypass.
module branch_bht
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int INDEX_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_taken,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int IW = $clog2(ENTRIES);

  logic [1:0]    r_cnt [ENTRIES];
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  logic          w_unused;

  assign w_rd_idx = i_lookup_pc[INDEX_LSB +: IW];
  assign w_wr_idx = i_upd_pc[INDEX_LSB +: IW];
  assign w_unused = ^{i_lookup_pc, i_upd_pc};

  // Read returns the stored value, so a same-cycle update is not visible.
  assign o_lookup_taken = r_cnt[w_rd_idx][1];

  // Reset all counters to weakly not-taken; train one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= WNT;
    end else if (i_upd_en) begin
      r_cnt[w_wr_idx] <= bht_next(r_cnt[w_wr_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/compare resolution with registered results,
// mispredict detection, BHT training and saturating perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_LSB   = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic [XLEN-1:0]  res_next_pc,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [XLEN-1:0]  slt_result,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [XLEN:0]   w_d;
  logic            w_c, w_z, w_n, w_v;
  logic            w_cond;
  logic            w_accept;
  logic            w_slt_f3;
  logic            w_br_ok;
  logic            w_illegal;
  logic            w_taken;
  logic            w_mis;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_slt;

  logic             r_valid, r_taken, r_mis, r_illegal;
  logic [XLEN-1:0]  r_next_pc, r_slt;
  logic [CNT_W-1:0] r_bcnt, r_mcnt;

  // rs1 - rs2 as a single carry-out subtraction.
  assign w_d = {1'b0, ex_rs1} + {1'b0, ~ex_rs2} + (XLEN+1)'(1);
  assign w_c = w_d[XLEN];
  assign w_z = (w_d[XLEN-1:0] == '0);
  assign w_n = w_d[XLEN-1];
  assign w_v = (ex_rs1[XLEN-1] != ex_rs2[XLEN-1]) &
               (w_d[XLEN-1] != ex_rs1[XLEN-1]);

  // Condition select by funct3.
  always_comb begin
    w_cond = 1'b0;
    unique case (ex_funct3)
      BEQ:  w_cond = w_z;
      BNE:  w_cond = ~w_z;
      BLT:  w_cond = w_n ^ w_v;
      BGE:  w_cond = ~(w_n ^ w_v);
      BLTU: w_cond = ~w_c;
      BGEU: w_cond = w_c;
      SLT:  w_cond = w_n ^ w_v;
      SLTU: w_cond = ~w_c;
    endcase
  end

  assign w_accept  = ex_valid & ~flush;
  assign w_slt_f3  = (ex_funct3 == SLT) | (ex_funct3 == SLTU);
  assign w_br_ok   = ex_is_branch & ~w_slt_f3;
  assign w_illegal = ex_is_branch ? w_slt_f3 : ~w_slt_f3;
  assign w_taken   = w_br_ok & w_cond;
  assign w_mis     = w_br_ok & (w_taken ^ ex_pred_taken);
  assign w_next_pc = w_taken ? ex_pc + ex_imm : ex_pc + XLEN'(4);
  assign w_slt     = (~ex_is_branch & w_slt_f3) ? XLEN'(w_cond) : '0;

  // Result registers: strobe every accepted op, hold fields otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_mis     <= 1'b0;
      r_illegal <= 1'b0;
      r_next_pc <= '0;
      r_slt     <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_taken   <= w_taken;
        r_mis     <= w_mis;
        r_illegal <= w_illegal;
        r_next_pc <= w_next_pc;
        r_slt     <= w_slt;
      end
    end
  end

  // Saturating counters of resolved and mispredicted legal branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else if (w_accept & w_br_ok) begin
      if (r_bcnt != '1) r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_mis && r_mcnt != '1) r_mcnt <= r_mcnt + CNT_W'(1);
    end
  end

  branch_bht #(
    .XLEN      (XLEN),
    .ENTRIES   (BHT_ENTRIES),
    .INDEX_LSB (INDEX_LSB)
  ) u_bht (
    .clk            (clk),
    .rst            (rst),
    .i_lookup_pc    (lookup_pc),
    .o_lookup_taken (lookup_taken),
    .i_upd_en       (w_accept & w_br_ok),
    .i_upd_pc       (ex_pc),
    .i_upd_taken    (w_taken)
  );

  assign res_valid      = r_valid;
  assign res_taken      = r_taken;
  assign res_next_pc    = r_next_pc;
  assign res_mispredict = r_mis;
  assign res_illegal    = r_illegal;
  assign slt_result     = r_slt;
  assign branch_cnt     = r_bcnt;
  assign mispredict_cnt = r_mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: issue side pushes hand-computed results into a queue,
// a negedge monitor pops and compares whenever res_valid is seen.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct {
    logic        taken;
    logic [31:0] npc;
    logic        mis;
    logic        ill;
    logic [31:0] slt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0, ex_imm = '0;
  logic        ex_pred_taken = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] res_next_pc, slt_result, branch_cnt, mispredict_cnt;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
    .res_next_pc(res_next_pc), .res_mispredict(res_mispredict),
    .res_illegal(res_illegal), .slt_result(slt_result),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected res_valid", 64'(res_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_taken", 64'(res_taken), 64'(e.taken));
        chk("res_next_pc", 64'(res_next_pc), 64'(e.npc));
        chk("res_mispredict", 64'(res_mispredict), 64'(e.mis));
        chk("res_illegal", 64'(res_illegal), 64'(e.ill));
        chk("slt_result", 64'(slt_result), 64'(e.slt));
        chk("branch_cnt", 64'(branch_cnt), 64'(e.bc));
        chk("mispredict_cnt", 64'(mispredict_cnt), 64'(e.mc));
      end
    end
  end

  // Called at posedge+1; presents one op for one edge.
  // If chk_pre, the lookup value seen before the edge is checked.
  task automatic issue(
    input logic br, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] pc, input logic [31:0] imm,
    input logic pred, input logic fl, input logic chk_pre,
    input logic pre, input exp_t e
  );
    ex_valid = 1'b1; ex_is_branch = br; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
    ex_pred_taken = pred; flush = fl;
    if (!fl) q.push_back(e);
    #1;
    if (chk_pre) chk("lookup pre-update", 64'(lookup_taken), 64'(pre));
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc,
                      input logic exp);
    lookup_pc = pc; #1;
    chk(nm, 64'(lookup_taken), 64'(exp));
  endtask

  function automatic exp_t mk(
    input logic t, input logic [31:0] n, input logic m,
    input logic il, input logic [31:0] s,
    input logic [31:0] bc, input logic [31:0] mc
  );
    exp_t e;
    e.taken = t; e.npc = n; e.mis = m; e.ill = il;
    e.slt = s; e.bc = bc; e.mc = mc;
    return e;
  endfunction

  exp_t nul;

  initial begin
    nul = mk(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset res_valid", 64'(res_valid), 64'd0);
    chk("reset branch_cnt", 64'(branch_cnt), 64'd0);
    lookup_pc = 32'h40; #1;
    chk("reset lookup", 64'(lookup_taken), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // BLT -1 < 1 taken, predicted not-taken
    issue(1, BLT, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 0, 0, 0, 0,
          mk(1, 32'h120, 1, 0, 0, 1, 1));
    // BEQ taken at 0x40, predicted taken
    issue(1, BEQ, 32'd5, 32'd5, 32'h40, 32'h10, 1, 0, 0, 0,
          mk(1, 32'h50, 0, 0, 0, 2, 1));
    look("lookup after one taken", 32'h40, 1);
    // BLTU 0xFFFFFFFF < 1 unsigned: not taken
    issue(1, BLTU, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 0, 0, 0, 0,
          mk(0, 32'h104, 0, 0, 0, 3, 1));
    // SLT overflow case, SLTU same operands, SLTU 1<2
    issue(0, SLT, 32'h80000000, 32'h7FFFFFFF, 32'h200, 0, 0, 0, 0, 0,
          mk(0, 32'h204, 0, 0, 1, 3, 1));
    issue(0, SLTU, 32'h80000000, 32'h7FFFFFFF, 32'h200, 0, 0, 0, 0, 0,
          mk(0, 32'h204, 0, 0, 0, 3, 1));
    issue(0, SLTU, 32'd1, 32'd2, 32'h200, 0, 0, 0, 0, 0,
          mk(0, 32'h204, 0, 0, 1, 3, 1));

    // Index 0 (currently 01): 4 taken, then 2 not-taken
    lookup_pc = 32'h300;
    issue(1, BGE, 32'd3, 32'd3, 32'h300, 32'hFFFFFFF0, 1, 0, 1, 0,
          mk(1, 32'h2F0, 0, 0, 0, 4, 1));
    issue(1, BGE, 32'd3, 32'd3, 32'h300, 32'hFFFFFFF0, 1, 0, 1, 1,
          mk(1, 32'h2F0, 0, 0, 0, 5, 1));
    issue(1, BGE, 32'd3, 32'd3, 32'h300, 32'hFFFFFFF0, 1, 0, 1, 1,
          mk(1, 32'h2F0, 0, 0, 0, 6, 1));
    issue(1, BGE, 32'd3, 32'd3, 32'h300, 32'hFFFFFFF0, 1, 0, 1, 1,
          mk(1, 32'h2F0, 0, 0, 0, 7, 1));
    issue(1, BGE, 32'd1, 32'd2, 32'h300, 32'hFFFFFFF0, 1, 0, 1, 1,
          mk(0, 32'h304, 1, 0, 0, 8, 2));
    issue(1, BGE, 32'd1, 32'd2, 32'h300, 32'hFFFFFFF0, 0, 0, 1, 1,
          mk(0, 32'h304, 0, 0, 0, 9, 2));
    look("lookup after 11->10->01", 32'h300, 0);

    issue(1, BNE, 32'd1, 32'd2, 32'h404, 32'd8, 1, 0, 0, 0,
          mk(1, 32'h40C, 0, 0, 0, 10, 2));
    issue(1, BGEU, 32'd0, 32'hFFFFFFFF, 32'h508, 32'h40, 1, 0, 0, 0,
          mk(0, 32'h50C, 1, 0, 0, 11, 3));

    // Flushed taken branch: no result, no training, no count
    issue(1, BEQ, 32'd0, 32'd0, 32'h80, 32'h8, 0, 1, 0, 0, nul);
    chk("flush res_valid", 64'(res_valid), 64'd0);
    chk("flush branch_cnt", 64'(branch_cnt), 64'd11);
    chk("flush mispredict_cnt", 64'(mispredict_cnt), 64'd3);
    look("flush no training", 32'h80, 0);

    // Illegal branch funct3 and illegal compare funct3
    issue(1, SLT, 32'd0, 32'd1, 32'h80, 32'h8, 1, 0, 0, 0,
          mk(0, 32'h84, 0, 1, 0, 11, 3));
    look("illegal no training", 32'h80, 0);
    issue(0, BEQ, 32'd9, 32'd9, 32'h90, 32'h8, 0, 0, 0, 0,
          mk(0, 32'h94, 0, 1, 0, 11, 3));

    // Train index 63 to 11, then reset mid-stream
    issue(1, BEQ, 32'd0, 32'd0, 32'hFC, 32'd4, 1, 0, 0, 0,
          mk(1, 32'h100, 0, 0, 0, 12, 3));
    issue(1, BEQ, 32'd0, 32'd0, 32'hFC, 32'd4, 1, 0, 0, 0,
          mk(1, 32'h100, 0, 0, 0, 13, 3));
    look("index 63 trained", 32'hFC, 1);
    issue(1, BNE, 32'd0, 32'd1, 32'h40, 32'h4, 0, 0, 0, 0, nul);
    #1; rst = 1'b1; #1;
    q.delete();
    chk("async rst res_valid", 64'(res_valid), 64'd0);
    chk("async rst res_next_pc", 64'(res_next_pc), 64'd0);
    chk("async rst res_taken", 64'(res_taken), 64'd0);
    chk("async rst res_mispredict", 64'(res_mispredict), 64'd0);
    chk("async rst branch_cnt", 64'(branch_cnt), 64'd0);
    chk("async rst mispredict_cnt", 64'(mispredict_cnt), 64'd0);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    look("post-reset index 63", 32'hFFFFFFFC, 0);
    // Wrapping target; one taken moves 01 -> 10
    issue(1, BEQ, 32'd7, 32'd7, 32'hFFFFFFFC, 32'd8, 0, 0, 1, 0,
          mk(1, 32'h4, 1, 0, 0, 1, 1));
    look("post-reset one taken", 32'hFFFFFFFC, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
